// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter: round-robin grant on ties, one transaction in flight,
// with a wait-state counter that aborts a stalled access after TIMEOUT cycles.
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic [DW-1:0] rdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic [DW-1:0] rdata1,
  output logic          ack1,
  output logic          err,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [4:0] TIMEOUT_CNT = 5'(TIMEOUT);
  localparam bit         TIMEOUT_ON  = (TIMEOUT != 0);

  state_t     state;
  state_t     state_next;
  logic       grant;
  logic       grant_next;
  logic       last_grant;
  logic [4:0] wait_cnt;
  logic [4:0] wait_cnt_inc;
  logic       timeout_hit;
  logic       start;

  assign start        = req0 || req1;
  assign wait_cnt_inc = wait_cnt + 5'd1;
  assign timeout_hit  = TIMEOUT_ON && (wait_cnt_inc == TIMEOUT_CNT);

  // On a tie the port that did not win last time gets the bus.
  assign grant_next = (req0 && req1) ? ~last_grant : req1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCESS;
      ACCESS:  if (mem_ready || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request operands are captured at grant so the bus stays stable even if the requester wanders.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            grant     <= grant_next;
            mem_we    <= grant_next ? we1 : we0;
            mem_addr  <= grant_next ? addr1 : addr0;
            mem_wdata <= grant_next ? wdata1 : wdata0;
            wait_cnt  <= '0;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            if (!mem_we) begin
              if (grant) rdata1 <= mem_rdata;
              else       rdata0 <= mem_rdata;
            end
            err <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt_inc;
            if (timeout_hit) begin
              err <= 1'b1;
              if (grant) rdata1 <= '1;
              else       rdata0 <= '1;
            end
          end
        end
        RESP: begin
          last_grant <= grant;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign mem_en = (state == ACCESS);
  assign ack0   = (state == RESP) && !grant;
  assign ack1   = (state == RESP) && grant;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations, then random
// requesters and memory checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 15;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic [DW-1:0] rdata0, rdata1;
  logic          ack0, ack1, err, busy, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .ack1(ack1),
    .err(err), .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input int port, input logic req, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      req0 = req; we0 = we; addr0 = addr; wdata0 = wdata;
    end else begin
      req1 = req; we1 = we; addr1 = addr; wdata1 = wdata;
    end
  endtask

  task automatic waitAck(input int port, input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      nextCycle();
      if ((port == 0) ? ack0 : ack1) begin
        cycles = i;
        return;
      end
    end
  endtask

  task automatic finishTxn();
    req0 = 1'b0;
    req1 = 1'b0;
    nextCycle();
  endtask

  // Memory: ready after mem_waits stall cycles of an access (-1 never); random mode re-picks per access.
  int          mem_waits  = 0;
  int          mem_cnt    = 0;
  bit          mem_random = 1'b0;
  logic [31:0] mem_data   = '0;
  int          wait_choices[7] = '{0, 0, 1, 3, 14, 15, 40};

  always @(negedge clock) begin
    if (mem_en) begin
      if (mem_random && mem_cnt == 0) mem_waits = wait_choices[$urandom_range(6)];
      mem_ready = (mem_cnt == mem_waits);
      mem_rdata = mem_random ? $urandom : mem_data;
      mem_cnt++;
    end else begin
      mem_cnt   = 0;
      mem_ready = 1'b0;
    end
  end

  // Transaction-level reference: one outstanding transfer, fair tie-break, response cycle after completion.
  bit          m_active = 0, m_resp = 0, m_we = 0, m_err = 0;
  int          m_port = 0, m_last = 1, m_waited = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [31:0] m_rdata [2] = '{32'h0, 32'h0};

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_active = 0; m_resp = 0; m_we = 0; m_err = 0;
      m_port = 0; m_last = 1; m_waited = 0;
      m_addr = '0; m_wdata = '0; m_rdata[0] = '0; m_rdata[1] = '0;
    end else if (m_resp) begin
      m_active = 0;
      m_resp   = 0;
      m_last   = m_port;
    end else if (m_active) begin
      if (mem_ready) begin
        if (!m_we) m_rdata[m_port] = mem_rdata;
        m_err  = 0;
        m_resp = 1;
      end else begin
        m_waited++;
        if (TIMEOUT != 0 && m_waited == TIMEOUT) begin
          m_err = 1;
          m_rdata[m_port] = 32'hFFFF_FFFF;
          m_resp = 1;
        end
      end
    end else if (req0 || req1) begin
      m_port   = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
      m_we     = (m_port == 1) ? we1 : we0;
      m_addr   = (m_port == 1) ? addr1 : addr0;
      m_wdata  = (m_port == 1) ? wdata1 : wdata0;
      m_waited = 0;
      m_active = 1;
    end
  end

  bit cmp_on = 1'b0;

  always @(negedge clock) begin
    if (cmp_on) begin
      checkBit("mem_en", mem_en, m_active && !m_resp);
      checkBit("busy", busy, m_active);
      checkBit("ack0", ack0, m_resp && m_port == 0);
      checkBit("ack1", ack1, m_resp && m_port == 1);
      checkBit("err", err, m_err);
      checkBit("mem_we", mem_we, m_we);
      checkOutput("mem_addr", mem_addr, m_addr);
      checkOutput("mem_wdata", mem_wdata, m_wdata);
      checkOutput("rdata0", rdata0, m_rdata[0]);
      checkOutput("rdata1", rdata1, m_rdata[1]);
    end
  end

  task automatic randomPort(input int port);
    logic r, a;
    r = (port == 0) ? req0 : req1;
    a = (port == 0) ? ack0 : ack1;
    if (r && a) begin
      if ($urandom_range(1) == 0) applyStimulus(port, 1'b1, 1'($urandom), $urandom, $urandom);
      else                        applyStimulus(port, 1'b0, 1'b0, '0, '0);
    end else if (!r) begin
      if ($urandom_range(2) == 0) applyStimulus(port, 1'b1, 1'($urandom), $urandom, $urandom);
    end else if (!busy && $urandom_range(15) == 0) begin
      applyStimulus(port, 1'b0, 1'b0, '0, '0);
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    cmp_on = 1'b1;

    // Reset held with a pending request: nothing moves.
    applyStimulus(0, 1'b1, 1'b0, 32'h100, 32'h0);
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      checkBit("reset mem_en", mem_en, 1'b0);
      checkBit("reset busy", busy, 1'b0);
      checkBit("reset ack0", ack0, 1'b0);
      checkOutput("reset mem_addr", mem_addr, 32'h0);
      checkOutput("reset rdata0", rdata0, 32'h0);
    end
    mem_waits = 0;
    mem_data  = 32'h1111_2222;
    reset = 1'b1;
    nextCycle();
    checkBit("post-reset mem_en", mem_en, 1'b1);
    checkOutput("post-reset mem_addr", mem_addr, 32'h100);
    nextCycle();
    checkBit("post-reset ack0", ack0, 1'b1);
    finishTxn();

    begin
      int cyc;
      // Zero-wait read on port 0.
      mem_data = 32'hCAFE_F00D;
      applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0);
      waitAck(0, 20, cyc);
      checkOutput("read latency", 32'(cyc), 32'd2);
      checkOutput("read rdata0", rdata0, 32'hCAFE_F00D);
      checkBit("read err", err, 1'b0);
      checkBit("read ack1", ack1, 1'b0);
      finishTxn();
      checkBit("read ack0 one pulse", ack0, 1'b0);

      // Write on port 1 with three wait states.
      mem_waits = 3;
      mem_data  = 32'hDEAD_BEEF;
      applyStimulus(1, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
      nextCycle();
      for (int k = 0; k < 4; k++) begin
        checkBit("write mem_we", mem_we, 1'b1);
        checkOutput("write mem_wdata", mem_wdata, 32'h1234_5678);
        checkOutput("write mem_addr", mem_addr, 32'h20);
        checkBit("write ack1 early", ack1, 1'b0);
        nextCycle();
      end
      checkBit("write ack1", ack1, 1'b1);
      checkOutput("write rdata1 kept", rdata1, 32'h0);
      finishTxn();
      checkBit("write ack1 one pulse", ack1, 1'b0);

      // Both ports hammering a zero-wait memory: strict alternation every 3 cycles.
      begin
        int ack_cyc[$];
        int ack_port[$];
        mem_waits = 0;
        applyStimulus(0, 1'b1, 1'b0, 32'h100, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'h200, 32'h0);
        for (int i = 0; i < 12; i++) begin
          nextCycle();
          if (ack0) begin ack_cyc.push_back(i); ack_port.push_back(0); end
          if (ack1) begin ack_cyc.push_back(i); ack_port.push_back(1); end
        end
        finishTxn();
        checkOutput("fair ack count", 32'(ack_cyc.size()), 32'd4);
        for (int i = 0; i < ack_cyc.size() && i < 4; i++) begin
          checkOutput("fair grant order", 32'(ack_port[i]), 32'(i % 2));
          checkOutput("fair ack cycle", 32'(ack_cyc[i]), 32'(1 + 3 * i));
        end
      end

      // Memory never ready: abort after TIMEOUT stalls.
      mem_waits = -1;
      applyStimulus(0, 1'b1, 1'b0, 32'h40, 32'h0);
      waitAck(0, 40, cyc);
      checkOutput("timeout latency", 32'(cyc), 32'd16);
      checkBit("timeout err", err, 1'b1);
      checkOutput("timeout rdata0", rdata0, 32'hFFFF_FFFF);
      finishTxn();
      checkBit("timeout err held", err, 1'b1);

      mem_waits = 0;
      mem_data  = 32'h0BAD_F00D;
      applyStimulus(0, 1'b1, 1'b0, 32'h44, 32'h0);
      waitAck(0, 20, cyc);
      checkOutput("after-timeout latency", 32'(cyc), 32'd2);
      checkBit("after-timeout err", err, 1'b0);
      checkOutput("after-timeout rdata0", rdata0, 32'h0BAD_F00D);
      finishTxn();

      // Ready lands on the same edge the counter would expire: ready wins.
      mem_waits = 14;
      mem_data  = 32'h0000_0077;
      applyStimulus(0, 1'b1, 1'b0, 32'h48, 32'h0);
      waitAck(0, 40, cyc);
      checkOutput("edge-ready latency", 32'(cyc), 32'd16);
      checkBit("edge-ready err", err, 1'b0);
      checkOutput("edge-ready rdata0", rdata0, 32'h0000_0077);
      finishTxn();

      // Reset in the middle of a stalled access.
      mem_waits = -1;
      applyStimulus(0, 1'b1, 1'b0, 32'h80, 32'h0);
      nextCycle();
      nextCycle();
      nextCycle();
      reset = 1'b0;
      #1;
      checkBit("mid-reset mem_en", mem_en, 1'b0);
      checkBit("mid-reset busy", busy, 1'b0);
      checkBit("mid-reset ack0", ack0, 1'b0);
      nextCycle();
      checkBit("mid-reset ack0 held", ack0, 1'b0);
      mem_waits = 0;
      reset = 1'b1;
      nextCycle();
      checkBit("regrant mem_en", mem_en, 1'b1);
      checkOutput("regrant mem_addr", mem_addr, 32'h80);
      nextCycle();
      checkBit("regrant ack0", ack0, 1'b1);
      finishTxn();
    end

    // Random traffic with occasional reset pulses.
    mem_random = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      nextCycle();
      reset = !(c % 750 == 400);
      randomPort(0);
      randomPort(1);
    end
    reset = 1'b1;
    finishTxn();
    for (int i = 0; i < 40; i++) nextCycle();
    cmp_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares one single-port memory bus between two requesters: port 0 is the cpu core's fetch/load/store path and port 1 is the program loader/debug DMA. It arbitrates with round-robin on ties, then runs one transaction at a time through a 3-state FSM. It waits a variable number of cycles for the memory's ready strobe, or aborts on a timeout, and returns read data with a one-cycle ack pulse per transaction. It sits between the cpu/loader and the memory model at the top level.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 15, max wait cycles for mem_ready before abort (1..31; 0 disables timeout)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
req0  input  1  port 0 request; held until ack0
we0  input  1  port 0 write enable (1=write, 0=read)
addr0  input  AW  port 0 address
wdata0  input  DW  port 0 write data
rdata0  output  DW  port 0 read data, valid when ack0=1
ack0  output  1  port 0 transaction complete, 1-cycle pulse
req1, we1, addr1, wdata1, rdata1, ack1  same as port 0, for port 1
err  output  1  timeout flag for the transaction being acked, valid with ack0/ack1
busy  output  1  FSM not in IDLE
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data, sampled when mem_ready=1
mem_ready  input  1  memory completes the access this cycle

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to IDLE. mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata0=rdata1=0, ack0=ack1=0, err=0, busy=0, wait counter=0, last_grant=1 (port 0 wins the first tie). A reset in the middle of a transaction aborts it and emits no ack.
- FSM states: IDLE=0, ACCESS=1, RESP=2. Encoding 3 is illegal and goes to IDLE on the next edge.
- IDLE: when either req is high at a rising edge:
  - Arbitrate: only one req → grant it. Both req → grant the port that is not last_grant.
  - Latch grant, the granted port's we/addr/wdata into mem_we/mem_addr/mem_wdata. Clear the wait counter. Go to ACCESS.
- ACCESS:
  - mem_en=1; mem_addr/mem_we/mem_wdata hold the latched values for the whole state, independent of requester inputs.
  - mem_ready=1 at an edge: for a read, capture mem_rdata into the granted port's rdata; for a write, rdata is unchanged. err<=0. Go to RESP.
  - Otherwise, wait counter +1. If TIMEOUT!=0 and the counter reaches TIMEOUT: set err<=1, load the granted rdata with all-ones, go to RESP.
  - mem_ready in the same edge as the timeout takes priority: no error.
- RESP:
  - ack of the granted port=1 for exactly this cycle; mem_en=0. last_grant<=grant. Go to IDLE.
  - err is valid only during the ack cycle and is held until the next RESP.
- Latency:
  - req sampled at edge k → mem_en high after edge k.
  - mem_ready sampled at edge k+1+n (n wait cycles) → ack high after that edge.
  - Zero-wait access: ack 2 cycles after req is sampled. Back-to-back: a new grant no earlier than the edge ending RESP, so 3 cycles per zero-wait transaction.
- Handshake:
  - A requester holds req and its operands stable until it sees ack.
  - A req still high in the IDLE cycle after ack is treated as a new request.
  - A req dropped before grant is ignored. A req dropped after grant does not cancel the transaction.
- busy = (state != IDLE). Non-granted rdata holds its value. Outputs are driven from registers or the state decode, with no combinational path from req to mem_*.

Test Plan:
- Reset: hold reset=0 with req0=1 → all outputs 0, no mem_en. Release → mem_en rises after the first edge, mem_addr=addr0.
- Single read: port 0 requests addr=0x10, memory returns 0xCAFEF00D with mem_ready on the first ACCESS cycle → ack0 pulses 1 cycle, 2 cycles after req, rdata0=0xCAFEF00D, err=0, ack1 stays 0.
- Write with waits: port 1 we1=1, addr=0x20, wdata=0x12345678, mem_ready after 3 wait cycles → mem_we=1 and mem_wdata=0x12345678 stable for 4 cycles, ack1 once, rdata1 unchanged.
- Tie fairness: req0 and req1 held high with zero-wait memory → grants alternate 0,1,0,1 and acks are 3 cycles apart.
- Timeout: TIMEOUT=15, mem_ready never asserted → ack0 after 15 wait cycles, err=1, rdata0=0xFFFFFFFF. The next transaction with ready gives err=0.
- Reset mid-ACCESS: pull reset low during a wait → no ack, state IDLE, mem_en=0. After release, a pending req is re-granted from scratch.
